hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer for the 16-bit 5-stage CPU (IF/ID/EX/M/WB). Drives the PC write enable, IF/ID write/flush,
//  ID/EX control-bubble select and the three forwarding selects (R0, op1, op2).
//  Runs the load-use and multi-cycle mul/div stall FSM and branch-flush sequencing. Sits in the ID stage.
// PARAMETERS
//  MUL_CYCLES  4   total cycles a multiply occupies ID (>=2)
//  DIV_CYCLES  16  total cycles a divide occupies ID (>=2)
//  CNT_W       5   width of the internal stall counter (must hold max(MUL,DIV)_CYCLES-1)
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  id_rs1         in   4   IF/ID instr[11:8]
//  id_rs2         in   4   IF/ID instr[7:4]
//  id_uses_rs2    in   1   ID instruction reads rs2
//  id_uses_r0     in   1   ID instruction reads R0 (branches, mul/div)
//  id_md_op       in   2   IF/ID multiDiv field; 2'b01 = mul, 2'b10 = div, else none
//  id_branch_taken in  1   raw comparator PCSrc
//  ex_rd, m_rd, wb_rd       in 4 each   destination register per stage
//  ex_reg_write, m_reg_write, wb_reg_write  in 2 each  [0] = writes rd, [1] = writes R0
//  ex_mem_read    in   1   EX-stage instruction is a load
//  pc_write       out  1   PC write enable
//  ifid_write     out  1   IF/ID write enable
//  ifid_flush     out  1   zero IF/ID on the next edge
//  idex_bubble    out  1   SignalFlushMux select (1 = zero the control bits)
//  pc_src         out  1   gated PCSrc to PCSourceMux
//  op1_fwd, op2_fwd, r0_fwd  out 2 each  00 = regfile, 01 = EX, 10 = M, 11 = WB
//  md_busy        out  1   mul/div sequencing in progress
// BEHAVIOUR
//  Reset: state = IDLE, cnt = 0. Next cycle: pc_write = 1, ifid_write = 1, ifid_flush = 0, idex_bubble = 0,
//   pc_src = 0, all fwd = 00, md_busy = 0.
//  Forwarding (combinational, priority EX > M > WB > 00):
//   - A stage matches operand r if reg_write[0] and rd == r.
//   - r0_fwd additionally matches on reg_write[1], or on reg_write[0] with rd == 0.
//  load_use = ex_mem_read & ex_reg_write[0] & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
//   - A load reaches the M stage before its data exists, so M forwarding of load data is illegal.
//  FSM states: IDLE, LOAD_STALL, MD_BUSY.
//   - IDLE, load_use: go to LOAD_STALL with cnt = 1; 2 stall cycles total, data then forwarded from WB.
//   - IDLE, id_md_op = mul or div: go to MD_BUSY with cnt = (MUL|DIV)_CYCLES - 2.
//   - LOAD_STALL: when cnt == 0, return to IDLE and re-evaluate; else cnt--.
//   - MD_BUSY: when cnt == 0, return to IDLE; else cnt--. The instruction issues to EX on the exit cycle.
//   - load_use and an md op together: LOAD_STALL first, MD_BUSY after it.
//  Stall cycle (load_use in IDLE, LOAD_STALL, or MD_BUSY with cnt != 0):
//   - pc_write = 0, ifid_write = 0, idex_bubble = 1, pc_src = 0.
//   - An id_branch_taken asserted during a stall is ignored; the branch re-resolves once released.
//  Branch: pc_src = id_branch_taken & ~stall; ifid_flush = pc_src (squashes the wrong-path instruction). 1-cycle penalty.
//  Stall and branch together: the stall wins; no flush.
//  Reset mid-stall: the FSM aborts to IDLE at the reset edge. cnt never wraps (saturates at 0).
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - adds outputs stall_cycles[15:0] and flush_count[15:0].
//   - Each increments per stall cycle / per ifid_flush and wraps at 16'hFFFF. Reset clears both.
//  HAZ_PERF_CNT_EN undefined: neither port nor any counter logic exists.
// STRUCTURE
//  Shared cpu_defs.vh holds:
//   - FWD_REG/FWD_EX/FWD_M/FWD_WB encodings and the HCU_IDLE/HCU_LOAD/HCU_MD state codes.
//   - MD_MUL/MD_DIV field values and the RW_RD/RW_R0 bit indices.
//  Sub-module fwd_select: purely combinational, one source register in, 2-bit select out.
//   Instantiated three times, with an R0_MODE parameter for the R0 compare.
// TESTING
//  1. Reset held 2 cycles mid-divide -> next cycle IDLE, pc_write = 1, md_busy = 0, all fwd = 00.
//  2. ex_rd = 3, ex_reg_write = 01, id_rs1 = 3, m_rd = 3 also writing -> op1_fwd = 01; clear EX write -> 10.
//  3. ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> pc_write = 0 and idex_bubble = 1 for
//     exactly 2 cycles, then op2_fwd = 11.
//  4. id_md_op = 10, DIV_CYCLES = 16 -> md_busy and pc_write = 0 for 15 cycles, released on the 16th.
//  5. id_branch_taken = 1 while IDLE, no hazard -> pc_src = 1 and ifid_flush = 1 in the same cycle.
//     With load_use also true -> pc_src = 0, ifid_flush = 0.
//  6. wb_reg_write = 10 (R0 write), id_uses_r0 -> r0_fwd = 11. With HAZ_PERF_CNT_EN, test 3 -> stall_cycles = 2.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the pipeline hazard control unit: forwarding selects,
// sequencer state codes, multiDiv field values and reg_write bit indices.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        HCU_IDLE = 2'd0,
        HCU_LOAD = 2'd1,
        HCU_MD   = 2'd2
    } hcu_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [1:0] MD_MUL = 2'b01;
    localparam logic [1:0] MD_DIV = 2'b10;

    localparam int RW_RD = 0;
    localparam int RW_R0 = 1;

    // R0 consumers also see writes flagged on the dedicated R0 write bit.
    function automatic logic stage_match(
        input logic [3:0] src_reg,
        input logic [3:0] stage_rd,
        input logic [1:0] stage_rw,
        input logic       r0_mode
    );
        logic rd_hit;
        logic r0_hit;
        rd_hit = stage_rw[RW_RD] && (stage_rd == src_reg);
        r0_hit = r0_mode && (stage_rw[RW_R0] || (stage_rw[RW_RD] && (stage_rd == 4'd0)));
        return rd_hit || r0_hit;
    endfunction

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Forwarding source select for one ID operand, priority EX > M > WB > regfile.
module hazard_control_unit_fwd_select
    import hazard_control_unit_pkg::*;
#(
    parameter bit R0_MODE = 1'b0
) (
    input  logic       use_en,
    input  logic [3:0] src_reg,
    input  logic [3:0] ex_rd,
    input  logic [3:0] m_rd,
    input  logic [3:0] wb_rd,
    input  logic [1:0] ex_reg_write,
    input  logic [1:0] m_reg_write,
    input  logic [1:0] wb_reg_write,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (use_en) begin
            if (stage_match(src_reg, ex_rd, ex_reg_write, R0_MODE)) begin
                fwd_sel = FWD_EX;
            end else if (stage_match(src_reg, m_rd, m_reg_write, R0_MODE)) begin
                fwd_sel = FWD_M;
            end else if (stage_match(src_reg, wb_rd, wb_reg_write, R0_MODE)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: load-use and mul/div stall sequencing, branch flush, operand forwarding.
// Optional HAZ_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       id_uses_r0,
    input  logic [1:0] id_md_op,
    input  logic       id_branch_taken,
    input  logic [3:0] ex_rd,
    input  logic [3:0] m_rd,
    input  logic [3:0] wb_rd,
    input  logic [1:0] ex_reg_write,
    input  logic [1:0] m_reg_write,
    input  logic [1:0] wb_reg_write,
    input  logic       ex_mem_read,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pc_src,
    output logic [1:0] op1_fwd,
    output logic [1:0] op2_fwd,
    output logic [1:0] r0_fwd,
    output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_CYCLES - 2);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             load_use;
    logic             md_start;
    logic             eval_idle;
    logic             stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HCU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        md_busy  = 1'b0;

        load_use = ex_mem_read && ex_reg_write[RW_RD] &&
                   ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        md_start = (id_md_op == MD_MUL) || (id_md_op == MD_DIV);

        // The last LOAD_STALL cycle releases and re-decodes the held instruction like IDLE.
        eval_idle = (state_q != HCU_MD) && !((state_q == HCU_LOAD) && (cnt_q != '0));

        if (eval_idle) begin
            state_d = HCU_IDLE;
            cnt_d   = '0;
            if (load_use) begin
                state_d = HCU_LOAD;
                cnt_d   = CNT_W'(1);
                stall   = 1'b1;
            end else if (md_start) begin
                state_d = HCU_MD;
                cnt_d   = (id_md_op == MD_DIV) ? DIV_LEN : MUL_LEN;
                stall   = 1'b1;
                md_busy = 1'b1;
            end
        end else begin
            stall   = (cnt_q != '0);
            md_busy = (state_q == HCU_MD) && (cnt_q != '0);
            if (cnt_q == '0) begin
                state_d = HCU_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall;
        pc_src      = id_branch_taken && !stall;
        ifid_flush  = pc_src;
    end

    hazard_control_unit_fwd_select #(.R0_MODE(1'b0)) u_fwd_op1 (
        .use_en      (1'b1),
        .src_reg     (id_rs1),
        .ex_rd       (ex_rd),
        .m_rd        (m_rd),
        .wb_rd       (wb_rd),
        .ex_reg_write(ex_reg_write),
        .m_reg_write (m_reg_write),
        .wb_reg_write(wb_reg_write),
        .fwd_sel     (op1_fwd)
    );

    hazard_control_unit_fwd_select #(.R0_MODE(1'b0)) u_fwd_op2 (
        .use_en      (1'b1),
        .src_reg     (id_rs2),
        .ex_rd       (ex_rd),
        .m_rd        (m_rd),
        .wb_rd       (wb_rd),
        .ex_reg_write(ex_reg_write),
        .m_reg_write (m_reg_write),
        .wb_reg_write(wb_reg_write),
        .fwd_sel     (op2_fwd)
    );

    hazard_control_unit_fwd_select #(.R0_MODE(1'b1)) u_fwd_r0 (
        .use_en      (id_uses_r0),
        .src_reg     (4'd0),
        .ex_rd       (ex_rd),
        .m_rd        (m_rd),
        .wb_rd       (wb_rd),
        .ex_reg_write(ex_reg_write),
        .m_reg_write (m_reg_write),
        .wb_reg_write(wb_reg_write),
        .fwd_sel     (r0_fwd)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {15'd0, stall};
        flush_count_d  = flush_count_q + {15'd0, ifid_flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
